// File: rtl/child_cluster_scheduler.sv
// child_cluster_scheduler
// Grants one shared child resource to N_CHILD requesters using non-preemptive
// round-robin arbitration. A grant is held from a one-cycle start pulse until
// the resource reports done, or until the watchdog forces a release.
//
// Handshake: a grant begins when start pulses with busy high. It ends when
// res_done is sampled high during BUSY, or when TIMEOUT_CYC BUSY cycles have
// elapsed without done. In the timeout case timeout_err pulses in the release
// cycle. res_done outside BUSY is ignored.
module child_cluster_scheduler #(
    parameter int N_CHILD     = 5,
    parameter int IDX_W       = $clog2(N_CHILD),
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CHILD-1:0] req,
    input  logic               res_done,
    output logic [N_CHILD-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               start,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [IDX_W:0]     N_L     = (IDX_W + 1)'(N_CHILD);
    localparam logic [IDX_W-1:0]   PTR_RST = IDX_W'(N_CHILD - 1);
    localparam logic [CNT_W-1:0]   TO_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
    localparam logic               WDOG_EN = (TIMEOUT_CYC != 0);
    localparam logic [N_CHILD-1:0] ONE_L   = N_CHILD'(1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q, start_d;
    logic               timeout_err_q, timeout_err_d;

    logic               arb_found;
    logic [IDX_W-1:0]   arb_sel;
    logic [IDX_W:0]     cand_sum;
    logic               wdog_hit;

    // Round-robin search: first set req bit starting just after ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        cand_sum  = '0;
        for (int i = 1; i <= N_CHILD; i++) begin
            cand_sum = {1'b0, ptr_q} + (IDX_W + 1)'(i);
            if (cand_sum >= N_L) begin
                cand_sum = cand_sum - N_L;
            end
            if (!arb_found && req[cand_sum[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_sel   = cand_sum[IDX_W-1:0];
            end
        end
    end

    // Watchdog fires on the last allowed BUSY cycle; res_done has priority.
    assign wdog_hit = WDOG_EN && (cnt_q == TO_LAST);

    // State and datapath registers; async reset returns to idle priority at child 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= PTR_RST;
            grant_idx_q   <= '0;
            cnt_q         <= '0;
            start_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_idx_q   <= grant_idx_d;
            cnt_q         <= cnt_d;
            start_q       <= start_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic: IDLE -> BUSY on any request, BUSY -> RELEASE on done or watchdog.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (arb_found) state_d = ST_BUSY;
            ST_BUSY:    if (res_done || wdog_hit) state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Datapath updates: capture winner, run watchdog, advance pointer on release.
    always_comb begin
        ptr_d         = ptr_q;
        grant_idx_d   = grant_idx_q;
        cnt_d         = cnt_q;
        start_d       = 1'b0;
        timeout_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_idx_d = arb_sel;
                    cnt_d       = '0;
                    start_d     = 1'b1;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!res_done && wdog_hit) begin
                    timeout_err_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                ptr_d = grant_idx_q;
            end
            default: begin
                ptr_d = ptr_q;
            end
        endcase
    end

    // Outputs: grant and busy follow the BUSY state; pulses come from registers.
    always_comb begin
        busy        = (state_q == ST_BUSY);
        grant       = busy ? (ONE_L << grant_idx_q) : '0;
        grant_idx   = grant_idx_q;
        start       = start_q;
        timeout_err = timeout_err_q;
    end

endmodule

// File: doc/child_cluster_scheduler.md
Name: child_cluster_scheduler

Overview:
- Sequences access to one shared child resource among N_CHILD requesting child instances of a generated module cluster.
- Requesters are served with non-preemptive round-robin arbitration.
- Issues a one-cycle start pulse to the shared resource and holds the grant until the resource reports done, or until a watchdog timeout expires.
- Sits beside the child instances inside the cluster's parent module.

Parameters:
- N_CHILD, 5, number of requesting child instances (2..16).
- IDX_W, $clog2(N_CHILD), width of the grant index.
- TIMEOUT_CYC, 64, maximum BUSY cycles before forced release; 0 disables the watchdog.
- CNT_W, 8, width of the watchdog counter; must hold TIMEOUT_CYC.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_CHILD  per-child request level.
- res_done  input  1  shared resource completion pulse.
- grant  output  N_CHILD  one-hot grant; all-zero when idle.
- grant_idx  output  IDX_W  index of the current or last granted child.
- start  output  1  one-cycle start pulse to the shared resource.
- busy  output  1  high while a grant is held.
- timeout_err  output  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset (async assert, synchronous release):
  - grant=0, grant_idx=0, start=0, busy=0, timeout_err=0.
  - State IDLE, watchdog counter 0.
  - Round-robin pointer ptr=N_CHILD-1, so child 0 has first priority.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - If req!=0, select the first set bit of req searching from ptr+1 upward, wrapping modulo N_CHILD.
  - Next cycle: grant=onehot(sel), grant_idx=sel, start=1, busy=1, counter=0, state BUSY.
  - If req=0, stay in IDLE with all outputs low.
- BUSY:
  - start is high only in the first BUSY cycle.
  - grant, grant_idx and busy are held.
  - The counter increments each BUSY cycle.
  - res_done is honoured in any BUSY cycle, including the start cycle. When it is seen, go to RELEASE next cycle.
- Watchdog: if TIMEOUT_CYC!=0, counter==TIMEOUT_CYC-1 and res_done=0, then next cycle timeout_err=1 for one cycle and state RELEASE.
  - If res_done and the timeout condition coincide, res_done wins and there is no timeout_err.
- RELEASE:
  - grant=0, busy=0, ptr=grant_idx; grant_idx keeps its value.
  - Next state is IDLE.
- Minimum gap between consecutive grants: done at cycle t, grant low at t+1 and t+2, next grant asserted at t+3.
- Latency: req rising at cycle t in IDLE gives grant and start at t+1.
- Non-preemptive:
  - Deasserting the granted child's req during BUSY does not drop the grant.
  - Other children's reqs are ignored until IDLE.
- res_done outside BUSY is ignored.
- Fairness: with all req bits held high, the grant order is 0,1,2,…,N_CHILD-1,0,…
- Reset mid-BUSY: all outputs drop to reset values immediately; no timeout_err and no stray start pulse.
- Invariants (verification asserts them):
  - grant is one-hot or zero.
  - start implies busy.
  - $countones(grant)==busy.

Test Plan:
- Single request: req=5'b00100 at cycle 10 -> grant=00100, grant_idx=2 and start=1 at cycle 11. res_done at 15 -> grant=0 at 16, busy low.
- Full round-robin: req=5'b11111 held, res_done pulsed 3 cycles after each start -> grant_idx sequence 0,1,2,3,4,0,1. No child starved, no timeout_err.
- Wrap and skip: ptr=3 and req=5'b01001 -> grant_idx=0 (bit 4 clear), then grant_idx=3 on the next arbitration.
- Timeout: TIMEOUT_CYC=8, req=00010, res_done never -> start at cycle c, timeout_err pulse at c+8, grant=0 at c+8. Next grant goes to a different requester if one is pending.
- Coincidence and corner cases:
  - res_done in the same cycle as start -> release next cycle with no timeout_err.
  - res_done and timeout in the same cycle -> no timeout_err.
  - res_done while IDLE -> no effect.
- Reset mid-operation: rst_n low during BUSY with grant=01000 -> grant=0 and busy=0 asynchronously. After release, req=01000 is granted again with a fresh start pulse, and ptr has restarted from 0 priority.
